// File: rtl/tlul_host_pkg.sv
// tlul_host_pkg: width helpers and constants for tlul_host_port and its
// transaction tracker. Widths derive from MaxOutstanding (1..8).
package tlul_host_pkg;

  // Source index width; at least 1 bit so a single-outstanding host still has a vector.
  function automatic int src_idx_w(input int max_out);
    return (max_out > 1) ? $clog2(max_out) : 1;
  endfunction

  // Counter must hold the value MaxOutstanding itself.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  localparam logic [1:0] TlSizeWord = 2'd2;
  localparam logic [3:0] MaskAll    = 4'hF;

endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL (32-bit data, 8-bit source) channel types and opcodes
// shared by every TL-UL agent in this slice.
//   tl_h2d_t : host -> device, the A channel plus d_ready
//   tl_d2h_t : device -> host, the D channel plus a_ready
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [15:0] TlAUserDefault = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_port_if.sv
// tlul_host_port_if: core-side req/gnt/rvalid memory interface.
//   master : the core (drives req_i, we_i, addr_i, be_i, wdata_i)
//   slave  : tlul_host_port (drives gnt_o, rvalid_o, rdata_o, err_o)
interface tlul_host_port_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (output req_i, we_i, addr_i, be_i, wdata_i,
                  input  gnt_o, rvalid_o, rdata_o, err_o);
  modport slave  (input  req_i, we_i, addr_i, be_i, wdata_i,
                  output gnt_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/tlul_host_txn_tracker.sv
// tlul_host_txn_tracker: in-flight transaction bookkeeping for tlul_host_port.
//   clock, reset    : clock, synchronous active-low reset
//   i_inc           : A-channel handshake this cycle
//   i_d_valid       : D beat presented this cycle
//   o_full/o_empty  : count == MaxOutstanding / count == 0
//   o_d_accept      : D beat matches an outstanding request
//   o_src_idx       : local source index for the next A request
//   o_proto_err     : registered pulse, D beat arrived with nothing outstanding
module tlul_host_txn_tracker
  import tlul_host_pkg::*;
#(
  parameter  int MaxOutstanding = 2,
  localparam int SrcIdxW        = src_idx_w(MaxOutstanding),
  localparam int CntW           = cnt_w(MaxOutstanding)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_inc,
  input  logic               i_d_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_d_accept,
  output logic [SrcIdxW-1:0] o_src_idx,
  output logic               o_proto_err
);

  logic [CntW-1:0]    r_count;
  logic [SrcIdxW-1:0] r_src_idx;
  logic               r_proto_err;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count >= CntW'(MaxOutstanding));
  assign o_d_accept  = i_d_valid & ~o_empty;
  assign o_src_idx   = r_src_idx;
  assign o_proto_err = r_proto_err;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count     <= '0;
      r_src_idx   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= i_d_valid & o_empty;
      // simultaneous issue and retire leaves the count unchanged
      if (i_inc & ~o_d_accept)
        r_count <= r_count + CntW'(1);
      else if (~i_inc & o_d_accept)
        r_count <= r_count - CntW'(1);
      if (i_inc)
        r_src_idx <= (r_src_idx == SrcIdxW'(MaxOutstanding - 1)) ? '0
                                                                 : r_src_idx + SrcIdxW'(1);
    end
  end

endmodule

// File: rtl/tlul_host_port.sv
// tlul_host_port: TL-UL initiator bridging a core req/gnt/rvalid port onto TL-UL.
// A channel is combinational from the core request (no A-side register);
// responses return in order, combinationally from the D channel.
//   clock, reset : clock, synchronous active-low reset
//   core         : tlul_host_port_if.slave (req/gnt/we/addr/be/wdata/rvalid/rdata/err)
//   proto_err_o  : 1-cycle pulse, D beat received with nothing outstanding
//   tl_o / tl_i  : TL-UL host->device / device->host
// Build option: TLUL_HOST_ALIGN_CHK_EN -- misaligned requests are answered locally
// with an error instead of being issued word-aligned.
module tlul_host_port
  import tlul_pkg::*;
  import tlul_host_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int SourceBase     = 0
) (
  input  logic                clock,
  input  logic                reset,
  tlul_host_port_if.slave     core,
  output logic                proto_err_o,
  output tlul_pkg::tl_h2d_t   tl_o,
  input  tlul_pkg::tl_d2h_t   tl_i
);

  localparam int SrcIdxW = src_idx_w(MaxOutstanding);

  logic               w_full, w_empty, w_d_accept;
  logic               w_a_valid, w_a_hs;
  logic               w_misalign, w_local_gnt, w_local_rsp;
  logic [SrcIdxW-1:0] w_src_idx;
  logic               w_unused_d;

`ifdef TLUL_HOST_ALIGN_CHK_EN
  logic r_local_rsp;
  assign w_misalign  = (core.addr_i[1:0] != 2'b00);
  // Only granted with nothing in flight, so the local error cannot overtake a D beat.
  assign w_local_gnt = core.req_i & w_misalign & w_empty & ~r_local_rsp;
  assign w_local_rsp = r_local_rsp;
  always_ff @(posedge clock) begin
    if (!reset) r_local_rsp <= 1'b0;
    else        r_local_rsp <= w_local_gnt;
  end
`else
  assign w_misalign  = 1'b0;
  assign w_local_gnt = 1'b0;
  assign w_local_rsp = 1'b0;
`endif

  assign w_a_valid  = core.req_i & ~w_misalign & ~w_full & ~w_local_rsp;
  assign w_a_hs     = w_a_valid & tl_i.a_ready;
  assign core.gnt_o = w_a_hs | w_local_gnt;

  tlul_host_txn_tracker #(.MaxOutstanding(MaxOutstanding)) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .i_inc       (w_a_hs),
    .i_d_valid   (tl_i.d_valid),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_d_accept  (w_d_accept),
    .o_src_idx   (w_src_idx),
    .o_proto_err (proto_err_o)
  );

  // A-channel fields are zeroed while idle so the bus is quiet without a request.
  always_comb begin
    tl_o         = '0;
    tl_o.d_ready = 1'b1;
    tl_o.a_valid = w_a_valid;
    if (core.req_i) begin
      tl_o.a_opcode  = !core.we_i ? Get :
                       (core.be_i == MaskAll) ? PutFullData : PutPartialData;
      tl_o.a_mask    = core.we_i ? core.be_i : MaskAll;
      tl_o.a_size    = TlSizeWord;
      tl_o.a_address = core.addr_i & ~32'h3;
      tl_o.a_source  = 8'(SourceBase) + 8'(w_src_idx);
      tl_o.a_data    = core.we_i ? core.wdata_i : '0;
      tl_o.a_user    = TlAUserDefault;
    end
  end

  assign core.rvalid_o = w_d_accept | w_local_rsp;

  always_comb begin
    core.rdata_o = '0;
    core.err_o   = 1'b0;
    if (w_local_rsp) begin
      core.err_o = 1'b1;
    end else if (w_d_accept) begin
      core.err_o = tl_i.d_error;
      if (tl_i.d_opcode == AccessAckData) core.rdata_o = tl_i.d_data;
    end
  end

  // Responses are in order, so the D routing fields carry no information here.
  assign w_unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink, tl_i.d_user};

endmodule
